keyboard_input: RTL and testbench

//  Turns PS/2 scan-code set 2 bytes from the PS/2 receiver into a 2-bit

---
 rtl/keyboard_input.sv | 98 +++++++++
 tb/tb_keyboard_input.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/keyboard_input.sv
// PS/2 scan-code set 2 decoder: tracks E0/F0 prefixes, keeps a held flag per
// horizontal direction and produces a registered 2-bit movement command.
module keyboard_input #(
  parameter logic [7:0] KEY_LEFT      = 8'h1C,
  parameter logic [7:0] KEY_RIGHT     = 8'h23,
  parameter logic [7:0] KEY_LEFT_EXT  = 8'h6B,
  parameter logic [7:0] KEY_RIGHT_EXT = 8'h74
) (
  input  logic       clk50m_i,
  input  logic       rst_n_i,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [1:0] movement_o,
  output logic [1:0] prefix_state_o
);

  // Byte handshake: received_data is sampled only on a rising edge where
  // received_data_en is high; there is no backpressure (no ready signal).

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   left_q, left_d;
  logic   right_q, right_d;
  logic   code_byte;
  logic   ext_ctx;
  logic   brk_ctx;
  logic   left_hit;
  logic   right_hit;

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    right_d   = right_q;
    code_byte = 1'b0;
    ext_ctx   = (state_q == EXT) || (state_q == EXT_BRK);
    brk_ctx   = (state_q == BRK) || (state_q == EXT_BRK);
    left_hit  = ext_ctx ? (received_data == KEY_LEFT_EXT)
                        : (received_data == KEY_LEFT);
    right_hit = ext_ctx ? (received_data == KEY_RIGHT_EXT)
                        : (received_data == KEY_RIGHT);

    if (received_data_en) begin
      unique case (state_q)
        IDLE: begin
          if (received_data == PREFIX_EXT)      state_d = EXT;
          else if (received_data == PREFIX_BRK) state_d = BRK;
          else                                  code_byte = 1'b1;
        end
        EXT: begin
          if (received_data == PREFIX_BRK) state_d = EXT_BRK;
          else                             code_byte = 1'b1;
        end
        BRK:     code_byte = 1'b1;
        EXT_BRK: code_byte = 1'b1;
        default: state_d = IDLE;
      endcase
    end

    // Any code byte ends the prefix sequence, matched or not.
    if (code_byte) begin
      state_d = IDLE;
      if (left_hit)  left_d  = !brk_ctx;
      if (right_hit) right_d = !brk_ctx;
    end
  end

  always_ff @(posedge clk50m_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      movement_o <= 2'b00;
    end else begin
      movement_o <= {right_q & ~left_q, left_q & ~right_q};
    end
  end

  assign prefix_state_o = state_q;

endmodule

// File: tb/tb_keyboard_input.sv
// Directed bench for keyboard_input: scan-code byte sequences with
// hand-computed movement results, plus latency and mid-sequence reset cases.
module tb_keyboard_input;

  logic       clk50m_i;
  logic       rst_n_i;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [1:0] movement_o;
  logic [1:0] prefix_state_o;

  int checks;
  int failures;
  logic [1:0] exp_q[$];

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [1:0] exp;
  } vec_t;

  vec_t tbl[24];

  keyboard_input dut (
    .clk50m_i        (clk50m_i),
    .rst_n_i         (rst_n_i),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .movement_o      (movement_o),
    .prefix_state_o  (prefix_state_o)
  );

  // Clock / reset
  initial begin
    clk50m_i = 1'b0;
    forever #10 clk50m_i = ~clk50m_i;
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk50m_i);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk50m_i);
    received_data_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk50m_i);
  endtask

  // Scoreboard
  task automatic check2(input string name, input logic [1:0] act);
    logic [1:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    received_data    = 8'h00;
    received_data_en = 1'b0;
    rst_n_i          = 1'b0;

    tbl[0]  = '{1, 8'h1C, 8'h00, 8'h00, 2'b01};  // A make
    tbl[1]  = '{2, 8'hF0, 8'h1C, 8'h00, 2'b00};  // A break
    tbl[2]  = '{2, 8'hE0, 8'h74, 8'h00, 2'b10};  // right arrow make
    tbl[3]  = '{1, 8'h74, 8'h00, 8'h00, 2'b10};  // bare 74 ignored
    tbl[4]  = '{3, 8'hE0, 8'hF0, 8'h74, 2'b00};  // right arrow break
    tbl[5]  = '{1, 8'h74, 8'h00, 8'h00, 2'b00};  // bare 74 does not set
    tbl[6]  = '{1, 8'h1C, 8'h00, 8'h00, 2'b01};
    tbl[7]  = '{1, 8'h23, 8'h00, 8'h00, 2'b00};  // both held
    tbl[8]  = '{2, 8'hF0, 8'h23, 8'h00, 2'b01};
    tbl[9]  = '{1, 8'h1C, 8'h00, 8'h00, 2'b01};  // typematic x5
    tbl[10] = '{1, 8'h1C, 8'h00, 8'h00, 2'b01};
    tbl[11] = '{1, 8'h1C, 8'h00, 8'h00, 2'b01};
    tbl[12] = '{1, 8'h1C, 8'h00, 8'h00, 2'b01};
    tbl[13] = '{1, 8'h1C, 8'h00, 8'h00, 2'b01};
    tbl[14] = '{1, 8'h29, 8'h00, 8'h00, 2'b01};  // unmatched make
    tbl[15] = '{2, 8'hF0, 8'h29, 8'h00, 2'b01};  // unmatched break
    tbl[16] = '{2, 8'hE0, 8'h6B, 8'h00, 2'b01};  // left arrow shares flag
    tbl[17] = '{2, 8'hF0, 8'h1C, 8'h00, 2'b00};  // A break clears shared flag
    tbl[18] = '{1, 8'hE1, 8'h00, 8'h00, 2'b00};  // pause byte unmatched
    tbl[19] = '{3, 8'hE0, 8'hE0, 8'h23, 2'b10};  // E0 in EXT is a code byte
    tbl[20] = '{2, 8'hF0, 8'hF0, 8'h00, 2'b10};  // F0 in BRK is a code byte
    tbl[21] = '{2, 8'hF0, 8'h23, 8'h00, 2'b00};
    tbl[22] = '{2, 8'hE0, 8'h1C, 8'h00, 2'b00};  // 1C in ext context unmatched
    tbl[23] = '{3, 8'hE0, 8'hF0, 8'h6B, 2'b00};

    // Reset state, held while en is low and data wiggles
    #10 rst_n_i = 1'b1;
    @(negedge clk50m_i);
    exp_q.push_back(2'b00); check2("reset_movement", movement_o);
    exp_q.push_back(2'd0);  check2("reset_state", prefix_state_o);
    received_data = 8'h1C;
    idle_cycles(4);
    exp_q.push_back(2'b00); check2("en_low_hold", movement_o);

    // One-cycle latency from the consuming edge
    @(negedge clk50m_i);
    received_data_en = 1'b1;
    @(negedge clk50m_i);
    received_data_en = 1'b0;
    exp_q.push_back(2'b00); check2("latency_before", movement_o);
    @(negedge clk50m_i);
    exp_q.push_back(2'b01); check2("latency_after", movement_o);
    send_byte(8'hF0);
    send_byte(8'h1C);
    idle_cycles(1);
    exp_q.push_back(2'b00); check2("latency_release", movement_o);

    // Table-driven vectors
    for (int v = 0; v < 24; v++) begin
      send_byte(tbl[v].b0);
      if (tbl[v].n > 1) send_byte(tbl[v].b1);
      if (tbl[v].n > 2) send_byte(tbl[v].b2);
      idle_cycles(1);
      exp_q.push_back(tbl[v].exp);
      check2($sformatf("vec%0d_movement", v), movement_o);
      exp_q.push_back(2'd0);
      check2($sformatf("vec%0d_state", v), prefix_state_o);
    end

    // Prefix states are visible while a sequence is pending
    send_byte(8'hE0);
    exp_q.push_back(2'd1); check2("state_ext", prefix_state_o);
    send_byte(8'hF0);
    exp_q.push_back(2'd3); check2("state_ext_brk", prefix_state_o);
    send_byte(8'h11);
    send_byte(8'hF0);
    exp_q.push_back(2'd2); check2("state_brk", prefix_state_o);
    send_byte(8'h11);

    // Reset mid-sequence: flags cleared at once, pending E0 discarded
    send_byte(8'hE0);
    send_byte(8'h74);
    idle_cycles(1);
    exp_q.push_back(2'b10); check2("pre_reset_right", movement_o);
    send_byte(8'hE0);
    rst_n_i = 1'b0;
    #1;
    exp_q.push_back(2'b00); check2("async_reset_movement", movement_o);
    exp_q.push_back(2'd0);  check2("async_reset_state", prefix_state_o);
    @(negedge clk50m_i);
    rst_n_i = 1'b1;
    idle_cycles(2);
    exp_q.push_back(2'b00); check2("post_reset_flags_clear", movement_o);
    send_byte(8'h74);
    idle_cycles(1);
    exp_q.push_back(2'b00); check2("prefix_discarded", movement_o);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
